// File: rtl/mem_access_unit_if.sv
// Data-memory access bundle: pipeline-side request/response signals plus the
// single-beat data bus. The slave modport is the memory-stage unit.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              mem_write;
    logic              wb_load;
    logic [1:0]        mem_store_type;
    logic [2:0]        mem_load_type;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       store_data;
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic [3:0]        bus_wstrb;
    logic [31:0]       bus_rdata;
    logic              bus_ack;
    logic              stall;
    logic [31:0]       load_data;
    logic              done;
    logic              misaligned;
    logic              bus_error;

    modport slave (
        input  req_valid, mem_write, wb_load, mem_store_type, mem_load_type,
        input  addr, store_data, bus_rdata, bus_ack,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output stall, load_data, done, misaligned, bus_error
    );

    modport master (
        output req_valid, mem_write, wb_load, mem_store_type, mem_load_type,
        output addr, store_data, bus_rdata, bus_ack,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  stall, load_data, done, misaligned, bus_error
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: one single-beat bus transaction per request,
// with lane steering, load extension, misalignment and ack-timeout detection.
module mem_access_unit #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave mif
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_bus_req, r_bus_we, r_is_load, r_err, r_mis;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [31:0]       r_bus_wdata, r_load_data;
    logic [3:0]        r_bus_wstrb;
    logic [2:0]        r_ltype;
    logic [1:0]        r_off;

    logic              w_store, w_load, w_mis, w_go, w_timeout;
    logic              w_stall, w_done, w_err;
    logic [31:0]       w_wdata, w_ext;
    logic [3:0]        w_wstrb;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;

    // Request decode; a store wins over a simultaneous load request.
    always_comb begin
        w_store = mif.req_valid && mif.mem_write && (mif.mem_store_type != 2'b11);
        w_load  = mif.req_valid && mif.wb_load && !mif.mem_write;
        w_mis   = 1'b0;
        if (w_store) begin
            case (mif.mem_store_type)
                2'b01:   w_mis = mif.addr[0];
                2'b10:   w_mis = |mif.addr[1:0];
                default: w_mis = 1'b0;
            endcase
        end else if (w_load) begin
            case (mif.mem_load_type)
                3'b000, 3'b100: w_mis = 1'b0;
                3'b001, 3'b101: w_mis = mif.addr[0];
                default:        w_mis = |mif.addr[1:0];
            endcase
        end
        w_go      = (w_store || w_load) && !w_mis;
        w_timeout = !mif.bus_ack && (r_cnt == CNT_W'(TIMEOUT - 1));
    end

    always_comb begin
        w_wdata = '0;
        w_wstrb = '0;
        if (w_store) begin
            case (mif.mem_store_type)
                2'b00: begin
                    w_wdata = {4{mif.store_data[7:0]}};
                    w_wstrb = 4'b0001 << mif.addr[1:0];
                end
                2'b01: begin
                    w_wdata = {2{mif.store_data[15:0]}};
                    w_wstrb = mif.addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    w_wdata = mif.store_data;
                    w_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        w_byte = mif.bus_rdata[{r_off, 3'b000} +: 8];
        w_half = r_off[1] ? mif.bus_rdata[31:16] : mif.bus_rdata[15:0];
        case (r_ltype)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'b0, w_byte};
            3'b101:  w_ext = {16'b0, w_half};
            default: w_ext = mif.bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_go) w_next = S_BUSY;
            S_BUSY:  if (mif.bus_ack || w_timeout) w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // Misaligned requests never leave IDLE; their done comes from r_mis.
    always_comb begin
        w_stall = (r_state == S_BUSY) || ((r_state == S_IDLE) && w_go);
        w_done  = (r_state == S_RESP) || r_mis;
        w_err   = (r_state == S_RESP) && r_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
            r_ltype     <= '0;
            r_off       <= '0;
            r_is_load   <= 1'b0;
            r_err       <= 1'b0;
            r_mis       <= 1'b0;
            r_load_data <= '0;
        end else begin
            r_mis <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_err <= 1'b0;
                    if (w_go) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= w_store;
                        r_bus_addr  <= {mif.addr[ADDR_W-1:2], 2'b00};
                        r_bus_wdata <= w_wdata;
                        r_bus_wstrb <= w_wstrb;
                        r_ltype     <= mif.mem_load_type;
                        r_off       <= mif.addr[1:0];
                        r_is_load   <= !w_store;
                    end else if (w_store || w_load) begin
                        r_mis <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (mif.bus_ack) begin
                        r_bus_req <= 1'b0;
                        if (r_is_load) r_load_data <= w_ext;
                    end else if (w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_err     <= 1'b1;
                        if (r_is_load) r_load_data <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mif.bus_req    = r_bus_req;
    assign mif.bus_we     = r_bus_we;
    assign mif.bus_addr   = r_bus_addr;
    assign mif.bus_wdata  = r_bus_wdata;
    assign mif.bus_wstrb  = r_bus_wstrb;
    assign mif.stall      = w_stall;
    assign mif.load_data  = r_load_data;
    assign mif.done       = w_done;
    assign mif.misaligned = r_mis;
    assign mif.bus_error  = w_err;
endmodule
